// File: rtl/fir_tdf_param_if.sv
// Sample, coefficient-write and filtered-output signals of fir_tdf_param.
// The master side is the sample source; the slave side is the filter.
interface fir_tdf_param_if #(
    parameter int TAPS = 10,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int OW   = 16
);
    localparam int AB = $clog2(TAPS);

    logic                 in_valid;
    logic signed [DW-1:0] x;
    logic                 coef_we;
    logic [AB-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [OW-1:0] y;
    logic                 sat;

    modport master (
        output in_valid, x, coef_we, coef_addr, coef_data,
        input  out_valid, y, sat
    );

    modport slave (
        input  in_valid, x, coef_we, coef_addr, coef_data,
        output out_valid, y, sat
    );
endinterface

// File: rtl/fir_tdf_param.sv
// Parametrised transposed-direct-form FIR with writable coefficients, rounding and saturation.
// Define FIR_ETA_EN to build the chain adders as ETA-I approximate adders.
module fir_tdf_param #(
    parameter int TAPS  = 10,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 14,
    parameter int ETA_K = 8
) (
    input  logic           clk,
    input  logic           rst,
    fir_tdf_param_if.slave bus
);
    localparam int AW     = DW + CW + $clog2(TAPS);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [AW:0]   ONE_W   = 1;
    localparam logic signed [AW:0]   RND     = (SHIFT > 0) ? (ONE_W <<< RND_SH) : '0;
    localparam logic signed [AW:0]   Y_MAX   = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0]   Y_MIN   = ~Y_MAX;
    localparam logic signed [CW-1:0] H_UNITY = CW'(1) << SHIFT;

    logic signed [CW-1:0] h    [TAPS];
    logic signed [AW-1:0] r    [TAPS];
    logic signed [AW-1:0] prod [TAPS];
    logic signed [AW-1:0] nxt  [TAPS];
    logic                 valid_d;
    logic signed [AW:0]   rounded;
    logic signed [AW:0]   shifted;
    logic                 clip_hi;
    logic                 clip_lo;
    logic signed [OW-1:0] y_next;

    // Both builds split at ETA_K; the approximate one drops the carry into the upper part.
`ifdef FIR_ETA_EN
    function automatic logic signed [AW-1:0] chain_add(input logic signed [AW-1:0] a,
                                                       input logic signed [AW-1:0] b);
        logic [AW-1:0] s;
        logic          hit;
        s   = '0;
        hit = 1'b0;
        s[AW-1:ETA_K] = a[AW-1:ETA_K] + b[AW-1:ETA_K];
        for (int i = ETA_K - 1; i >= 0; i--) begin
            if (hit || (a[i] && b[i])) begin
                s[i] = 1'b1;
                hit  = 1'b1;
            end else begin
                s[i] = a[i] ^ b[i];
            end
        end
        return $signed(s);
    endfunction
`else
    function automatic logic signed [AW-1:0] chain_add(input logic signed [AW-1:0] a,
                                                       input logic signed [AW-1:0] b);
        logic [AW-1:0] s;
        logic [ETA_K:0] lo;
        lo = {1'b0, a[ETA_K-1:0]} + {1'b0, b[ETA_K-1:0]};
        s  = '0;
        s[AW-1:ETA_K] = a[AW-1:ETA_K] + b[AW-1:ETA_K] + {{(AW-ETA_K-1){1'b0}}, lo[ETA_K]};
        s[ETA_K-1:0]  = lo[ETA_K-1:0];
        return $signed(s);
    endfunction
`endif

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod[k] = AW'(bus.x) * AW'(h[TAPS-1-k]);
        end
        nxt[0] = prod[0];
        for (int k = 1; k < TAPS; k++) begin
            nxt[k] = chain_add(r[k-1], prod[k]);
        end
    end

    // Writes land after this edge's chain update, so a coincident sample sees the old tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < TAPS; j++) begin
                h[j] <= (j == 0) ? H_UNITY : '0;
            end
        end else if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
            h[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r[k] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int k = 0; k < TAPS; k++) begin
                r[k] <= nxt[k];
            end
        end
    end

    always_comb begin
        rounded = {r[TAPS-1][AW-1], r[TAPS-1]} + RND;
        shifted = rounded >>> SHIFT;
        clip_hi = shifted > Y_MAX;
        clip_lo = shifted < Y_MIN;
        y_next  = shifted[OW-1:0];
        if (clip_hi) begin
            y_next = Y_MAX[OW-1:0];
        end else if (clip_lo) begin
            y_next = Y_MIN[OW-1:0];
        end
    end

    // The last chain register is sampled one cycle after acceptance, giving 2-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.sat       <= 1'b0;
        end else begin
            valid_d       <= bus.in_valid;
            bus.out_valid <= valid_d;
            if (valid_d) begin
                bus.y   <= y_next;
                bus.sat <= clip_hi | clip_lo;
            end
        end
    end
endmodule
